// File: rtl/top_fifo.sv
// Per-lane FIFO bank: one input word is split into KERNEL_SIZE lanes, and each lane drains on its own.
// Latency: 1 cycle from push to head visible, with first-word fall-through. Backpressure: input stalls while any lane is full.
// Optional: define TOP_FIFO_ZERO_EMPTY_EN to drive zeros on lanes with no valid entry.
module top_fifo #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    localparam int FULL_WIDTH = KERNEL_SIZE * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [FULL_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [KERNEL_SIZE-1:0] m_axis_tready,
    output logic [FULL_WIDTH-1:0]  m_axis_tdata,
    output logic [KERNEL_SIZE-1:0] m_axis_tvalid
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [KERNEL_SIZE-1:0] w_full;
    logic                   w_push;

    // All lanes advance together on input, so one full lane stalls the whole word.
    assign s_axis_tready = ~|w_full;
    assign w_push        = s_axis_tvalid & s_axis_tready;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [CNT_W-1:0]      r_count;
        logic                  w_vld;
        logic                  w_pop;
        logic [DATA_WIDTH-1:0] w_head;

        assign w_vld      = (r_count != '0);
        assign w_pop      = w_vld & m_axis_tready[gi];
        assign w_full[gi] = (r_count == CNT_W'(FIFO_DEPTH));
        assign w_head     = r_mem[r_rd_ptr];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage is deliberately left out of reset; occupancy alone defines validity.
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr] <= s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end

        assign m_axis_tvalid[gi] = w_vld;
`ifdef TOP_FIFO_ZERO_EMPTY_EN
        assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_vld ? w_head : '0;
`else
        assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_head;
`endif
    end

endmodule

// File: tb/tb_top_fifo.sv
// Directed bench for top_fifo at default parameters (3 lanes x 8 bits, depth 4).
module tb_top_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [2:0]  m_axis_tready = '0;
    logic [23:0] m_axis_tdata;
    logic [2:0]  m_axis_tvalid;

    int errors = 0;
    int checks = 0;

    top_fifo dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", s_axis_tready); end
        checks++;
        if (m_axis_tvalid !== 3'b000) begin errors++; $display("FAIL reset_vld: got %b want 000", m_axis_tvalid); end
        repeat (2) step();
        rstn = 1'b1;
        step();
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 3'b000) begin
            errors++; $display("FAIL post_reset: rdy=%b vld=%b want 1/000", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_fill();
        logic [23:0] words [4];
        words[0] = 24'hAABBCC; words[1] = 24'h112233; words[2] = 24'hDDEEFF; words[3] = 24'h445566;
        m_axis_tready = 3'b000;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = words[i];
            step();
            checks++;
            if (m_axis_tvalid !== 3'b111 || m_axis_tdata !== 24'hAABBCC) begin
                errors++; $display("FAIL fill_head%0d: vld=%b dat=%h want 111/aabbcc", i, m_axis_tvalid, m_axis_tdata);
            end
            checks++;
            if (s_axis_tready !== (i != 3)) begin
                errors++; $display("FAIL fill_rdy%0d: got %b want %b", i, s_axis_tready, (i != 3));
            end
        end
    endtask

    task automatic test_full_hold();
        s_axis_tdata  = 24'h778899;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_axis_tready !== 1'b0 || m_axis_tdata !== 24'hAABBCC) begin
                errors++; $display("FAIL hold%0d: rdy=%b dat=%h want 0/aabbcc", i, s_axis_tready, m_axis_tdata);
            end
        end
    endtask

    task automatic test_partial_pop();
        m_axis_tready = 3'b001;
        step();
        m_axis_tready = 3'b000;
        checks++;
        if (m_axis_tdata !== 24'hAABB33 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 3'b111) begin
            errors++; $display("FAIL lane0_pop: dat=%h rdy=%b vld=%b want aabb33/0/111", m_axis_tdata, s_axis_tready, m_axis_tvalid);
        end
        m_axis_tready = 3'b110;
        step();
        m_axis_tready = 3'b000;
        checks++;
        if (m_axis_tdata !== 24'h112233 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL lane12_pop: dat=%h rdy=%b want 112233/1", m_axis_tdata, s_axis_tready);
        end
        step();
        s_axis_tvalid = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tdata !== 24'h112233) begin
            errors++; $display("FAIL late_push: rdy=%b dat=%h want 0/112233", s_axis_tready, m_axis_tdata);
        end
    endtask

    task automatic test_drain();
        logic [23:0] exp_heads [3];
        exp_heads[0] = 24'hDDEEFF; exp_heads[1] = 24'h445566; exp_heads[2] = 24'h778899;
        m_axis_tready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (m_axis_tvalid !== 3'b111 || m_axis_tdata !== exp_heads[i]) begin
                errors++; $display("FAIL drain%0d: vld=%b dat=%h want 111/%h", i, m_axis_tvalid, m_axis_tdata, exp_heads[i]);
            end
        end
        step();
        m_axis_tready = 3'b000;
        checks++;
        if (m_axis_tvalid !== 3'b000 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL drained: vld=%b rdy=%b want 000/1", m_axis_tvalid, s_axis_tready);
        end
        // Read pointers have wrapped to slot 1, which last held 112233.
        checks++;
`ifdef TOP_FIFO_ZERO_EMPTY_EN
        if (m_axis_tdata !== 24'h000000) begin errors++; $display("FAIL empty_dat: got %h want 000000", m_axis_tdata); end
`else
        if (m_axis_tdata !== 24'h112233) begin errors++; $display("FAIL empty_dat: got %h want 112233", m_axis_tdata); end
`endif
    endtask

    task automatic test_back_to_back();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h010203;
        step();
        checks++;
        if (m_axis_tdata !== 24'h010203 || m_axis_tvalid !== 3'b111) begin
            errors++; $display("FAIL b2b_first: dat=%h vld=%b want 010203/111", m_axis_tdata, m_axis_tvalid);
        end
        s_axis_tdata  = 24'h040506;
        m_axis_tready = 3'b111;
        step();
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tdata !== 24'h040506 || m_axis_tvalid !== 3'b111 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL b2b_pushpop: dat=%h vld=%b rdy=%b want 040506/111/1", m_axis_tdata, m_axis_tvalid, s_axis_tready);
        end
        step();
        m_axis_tready = 3'b000;
        checks++;
        if (m_axis_tvalid !== 3'b000) begin errors++; $display("FAIL b2b_empty: vld=%b want 000", m_axis_tvalid); end
    endtask

    task automatic test_empty_pop();
        m_axis_tready = 3'b111;
        step();
        m_axis_tready = 3'b000;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h0A0B0C;
        step();
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 3'b111 || m_axis_tdata !== 24'h0A0B0C) begin
            errors++; $display("FAIL empty_pop: vld=%b dat=%h want 111/0a0b0c", m_axis_tvalid, m_axis_tdata);
        end
        m_axis_tready = 3'b010;
        step();
        checks++;
        if (m_axis_tvalid !== 3'b101) begin errors++; $display("FAIL lane1_only: vld=%b want 101", m_axis_tvalid); end
        m_axis_tready = 3'b111;
        step();
        m_axis_tready = 3'b000;
        checks++;
        if (m_axis_tvalid !== 3'b000) begin errors++; $display("FAIL lanes02_pop: vld=%b want 000", m_axis_tvalid); end
    endtask

    task automatic test_async_reset();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h111111;
        step();
        s_axis_tdata  = 24'h222222;
        step();
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 3'b111 || m_axis_tdata !== 24'h111111) begin
            errors++; $display("FAIL pre_arst: vld=%b dat=%h want 111/111111", m_axis_tvalid, m_axis_tdata);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 3'b000 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL arst_now: vld=%b rdy=%b want 000/1", m_axis_tvalid, s_axis_tready);
        end
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (m_axis_tvalid !== 3'b000 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL arst_after: vld=%b rdy=%b want 000/1", m_axis_tvalid, s_axis_tready);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_hold();
        test_partial_pop();
        test_drain();
        test_back_to_back();
        test_empty_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/top_fifo.md
TOP_FIFO -- requirements
Module: top_fifo

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3: number of lanes, one FIFO per lane.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries per lane FIFO; any value >= 2 is legal.
REQ-004 SHALL define FULL_WIDTH = KERNEL_SIZE*DATA_WIDTH.
REQ-005 SHALL have clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have s_axis_tdata, input, FULL_WIDTH bits: input word.
REQ-008 SHALL have s_axis_tvalid, input, 1 bit: input word valid.
REQ-009 SHALL have s_axis_tready, output, 1 bit: input word accepted.
REQ-010 SHALL have m_axis_tready, input, KERNEL_SIZE bits: per-lane consumer ready.
REQ-011 SHALL have m_axis_tdata, output, FULL_WIDTH bits: concatenated lane heads.
REQ-012 SHALL have m_axis_tvalid, output, KERNEL_SIZE bits: per-lane head valid.

Function
REQ-013 Lane i SHALL map to bits [i*DATA_WIDTH +: DATA_WIDTH] on both s_axis_tdata and m_axis_tdata; lane 0 is the LSB (word 0xAABBCC: lane0=CC, lane1=BB, lane2=AA).
REQ-014 s_axis_tready SHALL be combinational: 1 only when no lane FIFO is full; it SHALL NOT depend on s_axis_tvalid or m_axis_tready.
REQ-015 Push occurs at a clk edge when s_axis_tvalid=1 and s_axis_tready=1; every lane SHALL write its slice simultaneously.
REQ-016 m_axis_tvalid[i] SHALL be 1 when lane i holds at least 1 entry; a pushed word SHALL become visible the cycle after the push edge (latency 1).
REQ-017 m_axis_tdata lane i SHALL present the oldest entry of lane i (first-word fall-through).
REQ-018 Pop of lane i occurs at a clk edge when m_axis_tvalid[i]=1 and m_axis_tready[i]=1; lanes SHALL pop independently.
REQ-019 Same-edge push and pop on a non-empty, non-full lane SHALL leave its occupancy unchanged, with data order preserved.
REQ-020 When a lane is full, a pop SHALL free one entry; the blocked push SHALL complete on the next edge, not the same one.
REQ-021 When a lane is empty, a pop request SHALL be ignored.
REQ-022 Read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0; occupancy SHALL be tracked so that full and empty are unambiguous for any depth.

Reset
REQ-023 rstn=0 SHALL immediately clear all pointers and occupancy, with no clock required.
REQ-024 During and after reset: m_axis_tvalid=0, s_axis_tready=1; FIFO storage is not reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries.

Configuration
REQ-026 With macro TOP_FIFO_ZERO_EMPTY_EN defined, each lane of m_axis_tdata whose tvalid is 0 SHALL drive all zeros.
REQ-027 Without TOP_FIFO_ZERO_EMPTY_EN, each lane SHALL drive the storage entry at its read pointer, which may be stale when the lane is empty.

Verification
REQ-028 Reset with no traffic -> s_axis_tready=1, m_axis_tvalid=000.
REQ-029 Push AABBCC, 112233, DDEEFF, 445566 with m_axis_tready=000 -> after the 4th push s_axis_tready=0, m_axis_tvalid=111, m_axis_tdata=AABBCC.
REQ-030 Hold 778899 valid while full for 3 cycles -> stays unaccepted; then m_axis_tready=111 for 1 cycle -> m_axis_tdata=112233, s_axis_tready=1, 778899 is accepted on the next edge, s_axis_tready returns to 0.
REQ-031 While full, m_axis_tready=001 for 1 cycle -> only lane 0 advances (lane0=33, lane1=BB, lane2=AA); s_axis_tready stays 0.
REQ-032 m_axis_tready=111 until drained -> heads follow FIFO order, ending at 778899; then m_axis_tvalid=000, and m_axis_tdata=0 only when TOP_FIFO_ZERO_EMPTY_EN is defined.
REQ-033 Async reset mid-transfer with 2 entries stored -> immediately m_axis_tvalid=000, s_axis_tready=1.
